// File: rtl/roic_readout_sequencer.sv
// Sequences one ROIC frame: an integration window, then a row/column pixel scan on roic_clk.
// Each ADC sample is emitted as a backpressured stream beat; the scan stalls rather than drop samples.
module roic_readout_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 8,
  parameter int INT_W   = 24,
  parameter int DATA_W  = 14
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [INT_W-1:0]  cfg_int_time,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [COL_W-1:0]  cfg_cols,
  input  logic [DATA_W-1:0] adc_data,
  output logic              roic_int,
  output logic              roic_clk,
  output logic [ROW_W-1:0]  roic_row,
  output logic [COL_W-1:0]  roic_col,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INTEG,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       rst_pipe;
  logic             rst_core;
  logic [INT_W-1:0] int_cnt;
  logic [PH_W-1:0]  phase;
  logic [ROW_W-1:0] rows_sh;
  logic [COL_W-1:0] cols_sh;
  logic             stall;
  logic             take;

  // Reset asserts immediately but is released only after two ACLK edges.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rst_pipe <= 2'b11;
    else        rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_core = rst_pipe[1];
  assign stall    = m_tvalid && !m_tready;
  assign take     = m_tvalid && m_tready;

  always_ff @(posedge ACLK or posedge rst_core) begin
    if (rst_core) begin
      state     <= S_IDLE;
      int_cnt   <= '0;
      phase     <= '0;
      rows_sh   <= '0;
      cols_sh   <= '0;
      roic_int  <= 1'b0;
      roic_clk  <= 1'b0;
      roic_row  <= '0;
      roic_col  <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (take) m_tvalid <= 1'b0;

      if (cfg_abort && state != S_IDLE) begin
        // Abort discards any pending beat and returns silently to idle.
        state    <= S_IDLE;
        phase    <= '0;
        roic_int <= 1'b0;
        roic_clk <= 1'b0;
        roic_row <= '0;
        roic_col <= '0;
        m_tvalid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_start && !cfg_abort) begin
              rows_sh  <= cfg_rows;
              cols_sh  <= cfg_cols;
              int_cnt  <= (cfg_int_time == '0) ? '0 : cfg_int_time - INT_W'(1);
              roic_row <= '0;
              roic_col <= '0;
              roic_int <= 1'b1;
              busy     <= 1'b1;
              state    <= S_INTEG;
            end
          end

          S_INTEG: begin
            if (int_cnt == '0) begin
              roic_int <= 1'b0;
              phase    <= '0;
              state    <= S_CLK_LO;
            end else begin
              int_cnt <= int_cnt - INT_W'(1);
            end
          end

          S_CLK_LO: begin
            // Holding the low phase while a beat is unaccepted keeps the output register free for the next capture.
            if (!stall) begin
              if (phase == PH_LAST) begin
                phase    <= '0;
                roic_clk <= 1'b1;
                state    <= S_CLK_HI;
              end else begin
                phase <= phase + PH_W'(1);
              end
            end
          end

          S_CLK_HI: begin
            if (phase == PH_LAST) begin
              phase    <= '0;
              roic_clk <= 1'b0;
              m_tdata  <= adc_data;
              m_tvalid <= 1'b1;
              m_tuser  <= (roic_row == '0) && (roic_col == '0);
              m_tlast  <= (roic_col == cols_sh);
              if (roic_col == cols_sh) begin
                if (roic_row == rows_sh) begin
                  state <= S_DONE;
                end else begin
                  roic_col <= '0;
                  roic_row <= roic_row + ROW_W'(1);
                  state    <= S_CLK_LO;
                end
              end else begin
                roic_col <= roic_col + COL_W'(1);
                state    <= S_CLK_LO;
              end
            end else begin
              phase <= phase + PH_W'(1);
            end
          end

          S_DONE: begin
            if (!m_tvalid || m_tready) begin
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              busy      <= 1'b0;
              roic_row  <= '0;
              roic_col  <= '0;
              state     <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
